// File: rtl/uart_fir_frame_ctrl_if.sv
// uart_fir_frame_ctrl_if: UART/FIR side bundle of the frame controller.
// master = controller view, slave = UART/FIR environment view.
interface uart_fir_frame_ctrl_if #(
  parameter int IN_BYTES  = 2,
  parameter int OUT_BYTES = 2
);
  logic [7:0]             RxD_data;
  logic                   RxD_ready;
  logic [8*IN_BYTES-1:0]  FIR_in;
  logic                   FIR_strt;
  logic                   FIR_valid;
  logic [8*OUT_BYTES-1:0] FIR_out;
  logic [7:0]             TxD_data;
  logic                   TxD_start;
  logic                   TxD_busy;

  modport master (
    input  RxD_data, RxD_ready,
    input  FIR_valid, FIR_out, TxD_busy,
    output FIR_in, FIR_strt,
    output TxD_data, TxD_start
  );

  modport slave (
    output RxD_data, RxD_ready,
    output FIR_valid, FIR_out, TxD_busy,
    input  FIR_in, FIR_strt,
    input  TxD_data, TxD_start
  );
endinterface

// File: rtl/uart_fir_frame_ctrl.sv
// uart_fir_frame_ctrl: UART byte framing around a FIR core.
// FRAME_CTRL_OVR_CNT_EN adds the saturating ovr_cnt output.
module uart_fir_frame_ctrl #(
  parameter int IN_BYTES    = 2,
  parameter int OUT_BYTES   = 2,
  parameter int TIMEOUT_CYC = 100000,
  parameter int CNT_W       = 17
) (
  input  logic clk,
  input  logic rst,
  uart_fir_frame_ctrl_if.master bus,
  output logic busy,
  output logic frame_err,
  output logic overrun
`ifdef FRAME_CTRL_OVR_CNT_EN
  ,
  output logic [7:0] ovr_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_START,
    S_WFIR, S_SEND, S_WTX
  } state_t;

  localparam int MAXB =
    (IN_BYTES > OUT_BYTES) ? IN_BYTES : OUT_BYTES;
  localparam int CW = $clog2(MAXB) + 1;
  localparam int IW = 8 * IN_BYTES;
  localparam int OW = 8 * OUT_BYTES;
  localparam logic [CNT_W-1:0] TMO =
    CNT_W'(TIMEOUT_CYC);
  localparam logic [CW-1:0] IN_LAST =
    CW'(IN_BYTES - 1);
  localparam logic [CW-1:0] OUT_LAST =
    CW'(OUT_BYTES - 1);

  state_t state_q, state_d;

  logic [CW-1:0]    rx_cnt_q, rx_cnt_d;
  logic [CW-1:0]    tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [IW-1:0]    rxbuf_q, rxbuf_d;
  logic [IW-1:0]    fir_in_q, fir_in_d;
  logic [OW-1:0]    res_q, res_d;
  logic [7:0]       txd_q, txd_d;
  logic             strt_q, strt_d;
  logic             txs_q, txs_d;
  logic             busy_q, busy_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  logic [CNT_W-1:0] tmr_inc;
  logic             tmo_hit;
  logic             tx_done;
  int               rx_idx;
  int               tx_idx;

  assign tmr_inc = (tmr_q < TMO) ? tmr_q + 1'b1 : tmr_q;
  assign tmo_hit = (TIMEOUT_CYC > 0) && (tmr_inc == TMO);
  // txs_q marks the guard cycle right after a start
  assign tx_done = !txs_q && !bus.TxD_busy;
  assign rx_idx  = IN_BYTES - 1 - int'(rx_cnt_q);
  assign tx_idx  = OUT_BYTES - 1 - int'(tx_cnt_q);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (bus.RxD_ready)
          state_d = (IN_BYTES == 1) ? S_START : S_RECV;
      S_RECV:
        if (bus.RxD_ready) begin
          if (rx_cnt_q == IN_LAST) state_d = S_START;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end
      S_START: state_d = S_WFIR;
      S_WFIR:
        if (bus.FIR_valid) state_d = S_SEND;
      S_SEND:
        if (!bus.TxD_busy) state_d = S_WTX;
      S_WTX:
        if (tx_done)
          state_d = (tx_cnt_q == OUT_LAST) ? S_IDLE : S_SEND;
      default: state_d = S_IDLE;
    endcase
  end

  // output and datapath next values
  always_comb begin
    rx_cnt_d = rx_cnt_q;
    tx_cnt_d = tx_cnt_q;
    tmr_d    = tmr_q;
    rxbuf_d  = rxbuf_q;
    fir_in_d = fir_in_q;
    res_d    = res_q;
    txd_d    = txd_q;
    txs_d    = 1'b0;
    ferr_d   = 1'b0;
    strt_d   = (state_d == S_START);
    busy_d   = (state_d != S_IDLE);
    ovr_d    = bus.RxD_ready && (state_q inside
               {S_START, S_WFIR, S_SEND, S_WTX});
    unique case (state_q)
      S_IDLE:
        if (bus.RxD_ready) begin
          rxbuf_d[IW-8 +: 8] = bus.RxD_data;
          rx_cnt_d = CW'(1);
          tmr_d    = '0;
          if (IN_BYTES == 1) fir_in_d = rxbuf_d;
        end
      S_RECV:
        if (bus.RxD_ready) begin
          rxbuf_d[8*rx_idx +: 8] = bus.RxD_data;
          rx_cnt_d = rx_cnt_q + 1'b1;
          tmr_d    = '0;
          if (rx_cnt_q == IN_LAST) fir_in_d = rxbuf_d;
        end else if (tmo_hit) begin
          ferr_d   = 1'b1;
          rx_cnt_d = '0;
          tmr_d    = '0;
        end else begin
          tmr_d = tmr_inc;
        end
      S_WFIR:
        if (bus.FIR_valid) begin
          res_d    = bus.FIR_out;
          tx_cnt_d = '0;
        end
      S_SEND:
        if (!bus.TxD_busy) begin
          txd_d = res_q[8*tx_idx +: 8];
          txs_d = 1'b1;
        end
      S_WTX:
        if (tx_done) tx_cnt_d = tx_cnt_q + 1'b1;
      default: ;
    endcase
  end

  // datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
      tmr_q    <= '0;
      rxbuf_q  <= '0;
      fir_in_q <= '0;
      res_q    <= '0;
      txd_q    <= '0;
      strt_q   <= 1'b0;
      txs_q    <= 1'b0;
      busy_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      rx_cnt_q <= rx_cnt_d;
      tx_cnt_q <= tx_cnt_d;
      tmr_q    <= tmr_d;
      rxbuf_q  <= rxbuf_d;
      fir_in_q <= fir_in_d;
      res_q    <= res_d;
      txd_q    <= txd_d;
      strt_q   <= strt_d;
      txs_q    <= txs_d;
      busy_q   <= busy_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

`ifdef FRAME_CTRL_OVR_CNT_EN
  logic [7:0] ovr_cnt_q;

  // saturating count of dropped bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovr_cnt_q <= '0;
    else if (ovr_d && ovr_cnt_q != 8'hFF)
      ovr_cnt_q <= ovr_cnt_q + 1'b1;
  end

  assign ovr_cnt = ovr_cnt_q;
`endif

  assign bus.FIR_in    = fir_in_q;
  assign bus.FIR_strt  = strt_q;
  assign bus.TxD_data  = txd_q;
  assign bus.TxD_start = txs_q;
  assign busy          = busy_q;
  assign frame_err     = ferr_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_uart_fir_frame_ctrl.sv
// tb_uart_fir_frame_ctrl: directed bench for uart_fir_frame_ctrl.
// u0 defaults, u1 short timeout, u2 three-in/one-out bytes.
module tb_uart_fir_frame_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  uart_fir_frame_ctrl_if #(.IN_BYTES(2), .OUT_BYTES(2)) bus0 ();
  uart_fir_frame_ctrl_if #(.IN_BYTES(2), .OUT_BYTES(2)) bus1 ();
  uart_fir_frame_ctrl_if #(.IN_BYTES(3), .OUT_BYTES(1)) bus2 ();

  logic busy0, ferr0, ovr0;
  logic busy1, ferr1, ovr1;
  logic busy2, ferr2, ovr2;
`ifdef FRAME_CTRL_OVR_CNT_EN
  logic [7:0] oc0, oc1, oc2;
`endif

  uart_fir_frame_ctrl #(
    .IN_BYTES(2), .OUT_BYTES(2),
    .TIMEOUT_CYC(100000), .CNT_W(17)
  ) u0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .busy(busy0), .frame_err(ferr0), .overrun(ovr0)
`ifdef FRAME_CTRL_OVR_CNT_EN
    , .ovr_cnt(oc0)
`endif
  );

  uart_fir_frame_ctrl #(
    .IN_BYTES(2), .OUT_BYTES(2),
    .TIMEOUT_CYC(50), .CNT_W(6)
  ) u1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .busy(busy1), .frame_err(ferr1), .overrun(ovr1)
`ifdef FRAME_CTRL_OVR_CNT_EN
    , .ovr_cnt(oc1)
`endif
  );

  uart_fir_frame_ctrl #(
    .IN_BYTES(3), .OUT_BYTES(1),
    .TIMEOUT_CYC(100000), .CNT_W(17)
  ) u2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .busy(busy2), .frame_err(ferr2), .overrun(ovr2)
`ifdef FRAME_CTRL_OVR_CNT_EN
    , .ovr_cnt(oc2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int w, input logic v, input logic [7:0] b);
    case (w)
      0: begin bus0.RxD_ready = v; bus0.RxD_data = b; end
      1: begin bus1.RxD_ready = v; bus1.RxD_data = b; end
      default: begin bus2.RxD_ready = v; bus2.RxD_data = b; end
    endcase
  endtask

  task automatic rx(input int w, input logic [7:0] b);
    set_rx(w, 1'b1, b);
    tick();
    set_rx(w, 1'b0, 8'h00);
  endtask

  task automatic set_txb(input int w, input logic v);
    case (w)
      0: bus0.TxD_busy = v;
      1: bus1.TxD_busy = v;
      default: bus2.TxD_busy = v;
    endcase
  endtask

  task automatic fir_result(input int w, input logic [15:0] v);
    case (w)
      0: begin bus0.FIR_out = v; bus0.FIR_valid = 1'b1; end
      1: begin bus1.FIR_out = v; bus1.FIR_valid = 1'b1; end
      default: begin bus2.FIR_out = v[7:0]; bus2.FIR_valid = 1'b1; end
    endcase
    tick();
    bus0.FIR_valid = 1'b0;
    bus1.FIR_valid = 1'b0;
    bus2.FIR_valid = 1'b0;
  endtask

  // transmitter model: busy for 5 cycles after each start
  task automatic run_tx(input int w, output int n,
                        output logic [15:0] got, output int viol);
    int bcnt;
    logic pb, st;
    logic [7:0] d;
    n = 0; got = '0; viol = 0; bcnt = 0;
    set_txb(w, 1'b0);
    for (int c = 0; c < 80; c++) begin
      case (w)
        0: pb = bus0.TxD_busy;
        1: pb = bus1.TxD_busy;
        default: pb = bus2.TxD_busy;
      endcase
      tick();
      case (w)
        0: begin st = bus0.TxD_start; d = bus0.TxD_data; end
        1: begin st = bus1.TxD_start; d = bus1.TxD_data; end
        default: begin st = bus2.TxD_start; d = bus2.TxD_data; end
      endcase
      if (st) begin
        n++;
        got = {got[7:0], d};
        if (pb) viol++;
        bcnt = 5;
        set_txb(w, 1'b1);
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) set_txb(w, 1'b0);
      end
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++; if (bus0.FIR_in !== 16'h0) begin bad++; $display("FAIL rst_fir_in got=%h exp=0", bus0.FIR_in); end
    total++; if (bus0.FIR_strt !== 1'b0) begin bad++; $display("FAIL rst_strt got=%b exp=0", bus0.FIR_strt); end
    total++; if (bus0.TxD_start !== 1'b0) begin bad++; $display("FAIL rst_txs got=%b exp=0", bus0.TxD_start); end
    total++; if (bus0.TxD_data !== 8'h0) begin bad++; $display("FAIL rst_txd got=%h exp=0", bus0.TxD_data); end
    total++; if ({busy0, ferr0, ovr0} !== 3'b0) begin bad++; $display("FAIL rst_flags got=%b exp=000", {busy0, ferr0, ovr0}); end
    total++; if (bus2.FIR_in !== 24'h0) begin bad++; $display("FAIL rst_fir_in2 got=%h exp=0", bus2.FIR_in); end
    #2 rst = 1'b0;
  endtask

  task automatic test_rx_frame();
    rx(0, 8'h12);
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL rx_busy got=%b exp=1", busy0); end
    for (int i = 0; i < 19; i++) tick();
    total++; if (bus0.FIR_strt !== 1'b0) begin bad++; $display("FAIL rx_early_strt got=%b exp=0", bus0.FIR_strt); end
    rx(0, 8'h34);
    total++; if (bus0.FIR_strt !== 1'b1) begin bad++; $display("FAIL rx_strt got=%b exp=1", bus0.FIR_strt); end
    total++; if (bus0.FIR_in !== 16'h1234) begin bad++; $display("FAIL rx_fir_in got=%h exp=1234", bus0.FIR_in); end
    tick();
    total++; if (bus0.FIR_strt !== 1'b0) begin bad++; $display("FAIL rx_strt_len got=%b exp=0", bus0.FIR_strt); end
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL rx_busy_wait got=%b exp=1", busy0); end
  endtask

  task automatic test_tx();
    int n, viol;
    logic [15:0] got;
    tick();
    total++; if (bus0.TxD_start !== 1'b0) begin bad++; $display("FAIL tx_early got=%b exp=0", bus0.TxD_start); end
    fir_result(0, 16'hABCD);
    run_tx(0, n, got, viol);
    total++; if (n !== 2) begin bad++; $display("FAIL tx_count got=%0d exp=2", n); end
    total++; if (got !== 16'hABCD) begin bad++; $display("FAIL tx_bytes got=%h exp=abcd", got); end
    total++; if (viol !== 0) begin bad++; $display("FAIL tx_while_busy got=%0d exp=0", viol); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL tx_busy_end got=%b exp=0", busy0); end
  endtask

  task automatic test_timeout();
    int n, viol, first, cnt;
    logic [15:0] got;
    rx(1, 8'hAA);
    rx(1, 8'hBB);
    total++; if (bus1.FIR_in !== 16'hAABB) begin bad++; $display("FAIL to_first got=%h exp=aabb", bus1.FIR_in); end
    tick();
    fir_result(1, 16'h0000);
    run_tx(1, n, got, viol);
    total++; if (n !== 2) begin bad++; $display("FAIL to_drain got=%0d exp=2", n); end
    rx(1, 8'h12);
    first = -1; cnt = 0;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (ferr1) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    total++; if (first !== 50) begin bad++; $display("FAIL to_delay got=%0d exp=50", first); end
    total++; if (cnt !== 1) begin bad++; $display("FAIL to_pulses got=%0d exp=1", cnt); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL to_idle got=%b exp=0", busy1); end
    total++; if (bus1.FIR_in !== 16'hAABB) begin bad++; $display("FAIL to_keep got=%h exp=aabb", bus1.FIR_in); end
    rx(1, 8'h56);
    cnt = 0;
    for (int i = 1; i <= 49; i++) begin
      tick();
      if (ferr1) cnt++;
    end
    rx(1, 8'h78);
    if (ferr1) cnt++;
    total++; if (cnt !== 0) begin bad++; $display("FAIL to_byte_wins got=%0d exp=0", cnt); end
    total++; if (bus1.FIR_in !== 16'h5678) begin bad++; $display("FAIL to_next got=%h exp=5678", bus1.FIR_in); end
    total++; if (bus1.FIR_strt !== 1'b1) begin bad++; $display("FAIL to_strt got=%b exp=1", bus1.FIR_strt); end
  endtask

  task automatic test_overrun();
    int n, viol, ov, st;
    logic [15:0] got;
    ov = 0; st = 0;
    rx(0, 8'h11);
    rx(0, 8'h22);
    tick();
    set_rx(0, 1'b1, 8'hEE); tick(); ov += int'(ovr0);
    set_rx(0, 1'b0, 8'h00); tick(); ov += int'(ovr0);
    set_txb(0, 1'b1);
    fir_result(0, 16'h5AA5);
    ov += int'(ovr0);
    for (int k = 0; k < 2; k++) begin
      set_rx(0, 1'b1, 8'hEE); tick();
      ov += int'(ovr0); st += int'(bus0.TxD_start);
      set_rx(0, 1'b0, 8'h00); tick();
      ov += int'(ovr0); st += int'(bus0.TxD_start);
    end
    total++; if (ov !== 3) begin bad++; $display("FAIL ovr_pulses got=%0d exp=3", ov); end
    total++; if (st !== 0) begin bad++; $display("FAIL ovr_hold got=%0d exp=0", st); end
    run_tx(0, n, got, viol);
    total++; if (got !== 16'h5AA5) begin bad++; $display("FAIL ovr_bytes got=%h exp=5aa5", got); end
    total++; if (n !== 2) begin bad++; $display("FAIL ovr_count got=%0d exp=2", n); end
    total++; if (bus0.FIR_in !== 16'h1122) begin bad++; $display("FAIL ovr_fir_in got=%h exp=1122", bus0.FIR_in); end
`ifdef FRAME_CTRL_OVR_CNT_EN
    total++; if (oc0 !== 8'd3) begin bad++; $display("FAIL ovr_cnt got=%0d exp=3", oc0); end
`endif
  endtask

  task automatic test_async_reset();
    int n, viol;
    logic [15:0] got;
    rx(0, 8'h33);
    rx(0, 8'h44);
    tick();
    set_txb(0, 1'b1);
    fir_result(0, 16'hC0DE);
    tick();
    tick();
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL ar_pre_busy got=%b exp=1", busy0); end
    total++; if (bus0.TxD_data !== 8'hA5) begin bad++; $display("FAIL ar_pre_txd got=%h exp=a5", bus0.TxD_data); end
    #3 rst = 1'b1;
    #1;
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL ar_busy got=%b exp=0", busy0); end
    total++; if (bus0.FIR_in !== 16'h0) begin bad++; $display("FAIL ar_fir_in got=%h exp=0", bus0.FIR_in); end
    total++; if (bus0.TxD_data !== 8'h0) begin bad++; $display("FAIL ar_txd got=%h exp=0", bus0.TxD_data); end
    @(posedge clk);
    #3 rst = 1'b0;
    set_txb(0, 1'b0);
    tick();
    rx(0, 8'h01);
    rx(0, 8'h02);
    total++; if (bus0.FIR_in !== 16'h0102) begin bad++; $display("FAIL ar_fir_in2 got=%h exp=0102", bus0.FIR_in); end
    tick();
    fir_result(0, 16'hBEEF);
    run_tx(0, n, got, viol);
    total++; if (got !== 16'hBEEF) begin bad++; $display("FAIL ar_bytes got=%h exp=beef", got); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL ar_busy_end got=%b exp=0", busy0); end
  endtask

  task automatic test_back_to_back();
    int n, viol;
    logic [15:0] got;
    rx(2, 8'h01);
    rx(2, 8'h02);
    total++; if (bus2.FIR_strt !== 1'b0) begin bad++; $display("FAIL w_early got=%b exp=0", bus2.FIR_strt); end
    rx(2, 8'h03);
    total++; if (bus2.FIR_in !== 24'h010203) begin bad++; $display("FAIL w_fir_in got=%h exp=010203", bus2.FIR_in); end
    total++; if (bus2.FIR_strt !== 1'b1) begin bad++; $display("FAIL w_strt got=%b exp=1", bus2.FIR_strt); end
    tick();
    fir_result(2, 16'h007F);
    run_tx(2, n, got, viol);
    total++; if (n !== 1) begin bad++; $display("FAIL w_count got=%0d exp=1", n); end
    total++; if (got[7:0] !== 8'h7F) begin bad++; $display("FAIL w_byte got=%h exp=7f", got[7:0]); end
    total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL w_busy got=%b exp=0", busy2); end
  endtask

  initial begin
    bus0.RxD_data = '0; bus0.RxD_ready = 1'b0;
    bus0.FIR_valid = 1'b0; bus0.FIR_out = '0; bus0.TxD_busy = 1'b0;
    bus1.RxD_data = '0; bus1.RxD_ready = 1'b0;
    bus1.FIR_valid = 1'b0; bus1.FIR_out = '0; bus1.TxD_busy = 1'b0;
    bus2.RxD_data = '0; bus2.RxD_ready = 1'b0;
    bus2.FIR_valid = 1'b0; bus2.FIR_out = '0; bus2.TxD_busy = 1'b0;
    test_reset();
    test_rx_frame();
    test_tx();
    test_timeout();
    test_overrun();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
